// File: rtl/flo_scan.sv
// flo_scan: multi-cycle find-last-one / find-first-one engine.
//
// Scans a WID-bit vector CHUNK bits per clock. It stops at the first chunk
// that holds a set bit, or after the final chunk. The request carries a
// start position that masks the vector, so a caller can walk over the set
// bits one at a time.
//
// Ports:
//   clk      clock
//   rst      synchronous, active-high reset
//   i_valid  request valid
//   i_ready  request accepted when i_valid & i_ready at a clk edge
//   i_vec    vector to search (sampled at accept)
//   i_mode   0 = find last one (highest), 1 = find first one (lowest)
//   i_pos    inclusive start position (sampled at accept)
//   o_valid  result valid
//   o_ready  result consumed when o_valid & o_ready at a clk edge
//   o_idx    bit index of the hit, all-ones when nothing was found
//   o_found  1 when a set bit was found
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; i_ready=1
// SCAN  | examining one chunk per cycle, stops on a hit or the last chunk
// DONE  | result presented on o_valid until o_ready

module flo_scan #(
    parameter int WID   = 144,
    parameter int CHUNK = 48,
    parameter int OW    = $clog2(WID + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [WID-1:0] i_vec,
    input  logic          i_mode,
    input  logic [OW-1:0] i_pos,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [OW-1:0] o_idx,
    output logic          o_found
);

    localparam int NCH = (WID + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int CIW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam logic [CIW-1:0] CI_LAST = CIW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                       state;
    logic [NCH-1:0][CHUNK-1:0]    vec;
    logic                         mode;
    logic [CIW-1:0]               cidx;

    logic [PW-1:0]                mvec;
    logic [CHUNK-1:0]             cur;
    logic                         hit;
    logic [CW-1:0]                off;
    logic [OW-1:0]                hit_idx;
    logic                         last;

    // Start-position mask; the padding above WID-1 stays zero so the last
    // chunk can never produce a hit past the end of the vector.
    always_comb begin
        mvec = '0;
        for (int j = 0; j < WID; j++) begin
            if (i_mode)
                mvec[j] = i_vec[j] & (OW'(j) >= i_pos);
            else
                mvec[j] = i_vec[j] & (OW'(j) <= i_pos);
        end
    end

    assign cur = vec[cidx];

    // FFO keeps the first set bit seen walking up; FLO lets later
    // (higher) set bits overwrite, ending with the highest.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int b = 0; b < CHUNK; b++) begin
            if (cur[b] && (!mode || !hit))
                off = CW'(b);
            if (cur[b])
                hit = 1'b1;
        end
    end

    assign hit_idx = OW'(int'(cidx) * CHUNK + int'(off));
    assign last    = mode ? (cidx == CI_LAST) : (cidx == '0);

    // Gated by rst so no request can be taken while reset is held.
    assign i_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_found <= 1'b0;
            o_idx   <= '1;
            vec     <= '0;
            mode    <= 1'b0;
            cidx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        vec   <= mvec;
                        mode  <= i_mode;
                        cidx  <= i_mode ? '0 : CI_LAST;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        o_idx   <= hit_idx;
                        o_found <= 1'b1;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end else if (last) begin
                        o_idx   <= '1;
                        o_found <= 1'b0;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cidx <= mode ? cidx + 1'b1 : cidx - 1'b1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flo_scan.sv
// tb_flo_scan: self-checking bench for flo_scan (WID=144, CHUNK=48).
// Directed table, hand-written corner sequences, then random requests
// checked against a bit-loop reference model.

module tb_flo_scan;

    localparam int WID   = 144;
    localparam int CHUNK = 48;
    localparam int OW    = 8;
    localparam int NCH   = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid;
    logic           i_ready;
    logic [WID-1:0] i_vec;
    logic           i_mode;
    logic [OW-1:0]  i_pos;
    logic           o_valid;
    logic           o_ready;
    logic [OW-1:0]  o_idx;
    logic           o_found;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    flo_scan #(.WID(WID), .CHUNK(CHUNK)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_vec   (i_vec),
        .i_mode  (i_mode),
        .i_pos   (i_pos),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_idx   (o_idx),
        .o_found (o_found)
    );

    typedef struct {
        logic [WID-1:0] vec;
        logic           mode;
        logic [OW-1:0]  pos;
        logic [OW-1:0]  idx;
        logic           found;
        int             lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [WID-1:0] bit1(input int b);
        logic [WID-1:0] r;
        r    = '0;
        r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [WID-1:0] rand_vec();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[WID-1:0];
    endfunction

    function automatic vec_t mk(input logic [WID-1:0] v, input logic m, input int p,
                                input int idx, input logic f, input int lat);
        vec_t r;
        r.vec   = v;
        r.mode  = m;
        r.pos   = OW'(p);
        r.idx   = OW'(idx);
        r.found = f;
        r.lat   = lat;
        return r;
    endfunction

    // Reference: walk the bits in search order applying the position rule;
    // latency is how many chunks the walk touched.
    task automatic ref_model(input logic [WID-1:0] v, input logic m, input logic [OW-1:0] p,
                             output logic [OW-1:0] idx, output logic fnd, output int lat);
        idx = '1;
        fnd = 1'b0;
        lat = NCH;
        if (!m) begin
            for (int b = WID - 1; b >= 0; b--) begin
                if (v[b] && b <= int'(p)) begin
                    idx = OW'(b); fnd = 1'b1; lat = NCH - b / CHUNK;
                    break;
                end
            end
        end else begin
            for (int b = 0; b < WID; b++) begin
                if (v[b] && b >= int'(p)) begin
                    idx = OW'(b); fnd = 1'b1; lat = b / CHUNK + 1;
                    break;
                end
            end
        end
    endtask

    // One full request/response. Called #1 after a posedge. With hold>0 the
    // result is stalled for hold cycles while i_vec is scrambled.
    task automatic run_op(input logic [WID-1:0] v, input logic m, input logic [OW-1:0] p,
                          input int hold, output logic [OW-1:0] idx, output logic fnd,
                          output int lat);
        int guard;
        guard = 0;
        while (!i_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("i_ready_before_accept", i_ready, 1);
        i_vec   = v;
        i_mode  = m;
        i_pos   = p;
        i_valid = 1'b1;
        o_ready = (hold == 0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_vec   = rand_vec();
        i_mode  = ~m;
        i_pos   = OW'($urandom_range(0, 255));
        chk("i_ready_in_scan", i_ready, 0);
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("o_valid_timeout", o_valid, 1);
        idx = o_idx;
        fnd = o_found;
        for (int h = 0; h < hold; h++) begin
            i_vec = rand_vec();
            @(posedge clk); #1;
            chk("stall_o_valid", o_valid, 1);
            chk("stall_o_idx", o_idx, idx);
            chk("stall_o_found", o_found, fnd);
            chk("stall_i_ready", i_ready, 0);
        end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        chk("turnaround_o_valid", o_valid, 0);
        chk("turnaround_i_ready", i_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WID-1:0] v2;
        logic [OW-1:0]  idx, eidx;
        logic           fnd, efnd;
        int             lat, elat, steps, guard;
        logic           seen;
        int             it_idx[4];
        int             it_lat[4];

        v2 = bit1(100) | bit1(5);

        rst     = 1'b1;
        i_valid = 1'b0;
        i_vec   = '0;
        i_mode  = 1'b0;
        i_pos   = '0;
        o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_idx", o_idx, 255);
        chk("reset_o_found", o_found, 0);
        chk("reset_i_ready", i_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_i_ready", i_ready, 1);

        tbl[0]  = mk(v2,     1'b0, 143, 100, 1'b1, 1);
        tbl[1]  = mk(v2,     1'b1, 0,   5,   1'b1, 1);
        tbl[2]  = mk(v2,     1'b0, 99,  5,   1'b1, 3);
        tbl[3]  = mk('0,     1'b0, 143, 255, 1'b0, 3);
        tbl[4]  = mk('0,     1'b1, 0,   255, 1'b0, 3);
        tbl[5]  = mk('1,     1'b1, 200, 255, 1'b0, 3);
        tbl[6]  = mk('1,     1'b0, 200, 143, 1'b1, 1);
        tbl[7]  = mk(v2,     1'b1, 100, 100, 1'b1, 3);
        tbl[8]  = mk(v2,     1'b1, 101, 255, 1'b0, 3);
        tbl[9]  = mk(v2,     1'b0, 4,   255, 1'b0, 3);
        tbl[10] = mk(bit1(47), 1'b1, 0, 47,  1'b1, 1);
        tbl[11] = mk(bit1(48), 1'b1, 0, 48,  1'b1, 2);

        for (int t = 0; t < 12; t++) begin
            run_op(tbl[t].vec, tbl[t].mode, tbl[t].pos, 0, idx, fnd, lat);
            chk($sformatf("tbl%0d_idx", t), idx, tbl[t].idx);
            chk($sformatf("tbl%0d_found", t), fnd, tbl[t].found);
            chk($sformatf("tbl%0d_lat", t), lat, tbl[t].lat);
        end

        // FLO iteration over {143, 96, 47, 0}
        it_idx = '{143, 96, 47, 0};
        it_lat = '{1, 1, 3, 3};
        i_pos  = OW'(143);
        idx    = OW'(143);
        steps  = 0;
        guard  = 0;
        while (guard < 8) begin
            run_op(bit1(143) | bit1(96) | bit1(47) | bit1(0), 1'b0, idx, 0, idx, fnd, lat);
            if (steps < 4) begin
                chk($sformatf("iter%0d_idx", steps), idx, it_idx[steps]);
                chk($sformatf("iter%0d_lat", steps), lat, it_lat[steps]);
            end
            steps++;
            guard++;
            if (!fnd || idx == 0) break;
            idx = idx - 1'b1;
        end
        chk("iter_steps", steps, 4);

        // backpressure with i_vec toggling while stalled
        run_op(v2, 1'b0, OW'(143), 5, idx, fnd, lat);
        chk("bp_idx", idx, 100);
        chk("bp_found", fnd, 1);
        chk("bp_lat", lat, 1);

        // leave a non-reset result, then reset during SCAN cycle 2 of a miss
        run_op(bit1(0), 1'b1, '0, 0, idx, fnd, lat);
        chk("pre_rst_idx", idx, 0);
        i_vec   = '0;
        i_mode  = 1'b0;
        i_pos   = OW'(143);
        i_valid = 1'b1;
        o_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_scan_o_valid", o_valid, 0);
        chk("rst_scan_o_idx", o_idx, 255);
        chk("rst_scan_o_found", o_found, 0);
        chk("rst_scan_i_ready", i_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_scan_release_i_ready", i_ready, 1);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1'b1;
        end
        chk("rst_scan_no_emit", seen, 0);
        o_ready = 1'b0;

        // reset while DONE is stalled
        i_vec   = v2;
        i_mode  = 1'b0;
        i_pos   = OW'(143);
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        chk("done_stall_o_valid", o_valid, 1);
        chk("done_stall_o_idx", o_idx, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_done_o_valid", o_valid, 0);
        chk("rst_done_o_idx", o_idx, 255);
        chk("rst_done_o_found", o_found, 0);
        @(posedge clk); #1;
        chk("rst_done_release_i_ready", i_ready, 1);

        // random requests against the reference model
        for (int n = 0; n < 300; n++) begin
            logic           m;
            logic [OW-1:0]  p;
            logic [WID-1:0] v;
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) p = OW'($urandom_range(0, 255));
            else                           p = OW'($urandom_range(0, WID - 1));
            case ($urandom_range(0, 4))
                0:       v = '0;
                1:       v = bit1($urandom_range(0, WID - 1));
                2:       v = rand_vec() & rand_vec() & rand_vec() & rand_vec();
                3:       v = rand_vec();
                default: v = rand_vec() & rand_vec();
            endcase
            ref_model(v, m, p, eidx, efnd, elat);
            run_op(v, m, p, $urandom_range(0, 2), idx, fnd, lat);
            chk($sformatf("rnd%0d_idx", n), idx, eidx);
            chk($sformatf("rnd%0d_found", n), fnd, efnd);
            chk($sformatf("rnd%0d_lat", n), lat, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
